img_flow_sequencer: RTL and testbench

IMG_FLOW_SEQUENCER -- requirements
Module: img_flow_sequencer

---
 rtl/img_flow_sequencer.sv | 173 +++++++++++++++++
 tb/tb_img_flow_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/img_flow_sequencer.sv
// Sequences an image job through rx, optional conv and tx controllers and hands the single SRAM to the active phase.
// Each phase is a start pulse, a bounded wait for busy to rise, then an unbounded wait for busy to fall.
package img_sram_pkg;
    typedef struct packed {
        logic        cs;
        logic        we;
        logic [5:0]  addr;
        logic [3:0]  be;
        logic [31:0] wdat;
    } img_sram_ctrl_t;
endpackage

module img_flow_sequencer
    import img_sram_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           bypass_conv,
    input  logic [7:0]     nrows_in,
    input  logic [7:0]     ncols_in,
    output logic [7:0]     nrows,
    output logic [7:0]     ncols,
    output logic           rx_en,
    output logic           conv_en,
    output logic           tx_en,
    input  logic           rx_busy,
    input  logic           conv_busy,
    input  logic           tx_busy,
    input  img_sram_ctrl_t rx_sram_ctrl,
    input  img_sram_ctrl_t conv_sram_ctrl,
    input  img_sram_ctrl_t tx_sram_ctrl,
    output img_sram_ctrl_t sram_ctrl,
    output logic [1:0]     phase,
    output logic           busy,
    output logic           done,
    output logic           err
);

    if (ACK_TIMEOUT == 0 || ACK_TIMEOUT > 255) begin : g_bad_timeout
        $error("ACK_TIMEOUT must be in 1..255");
    end

    localparam logic [7:0] ACK_LIM = ACK_TIMEOUT[7:0];

    typedef enum logic [3:0] {
        S_IDLE, S_RX_GO, S_RX_ACK, S_RX_RUN, S_CV_GO, S_CV_ACK, S_CV_RUN,
        S_TX_GO, S_TX_ACK, S_TX_RUN, S_DONE, S_ERROR
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] nrows_q, nrows_d;
    logic [7:0] ncols_q, ncols_d;
    logic       byp_q, byp_d;
    logic       done_q, done_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            nrows_q <= 8'd0;
            ncols_q <= 8'd0;
            byp_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            nrows_q <= nrows_d;
            ncols_q <= ncols_d;
            byp_q   <= byp_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        nrows_d   = nrows_q;
        ncols_d   = ncols_q;
        byp_d     = byp_q;
        rx_en     = 1'b0;
        conv_en   = 1'b0;
        tx_en     = 1'b0;
        phase     = 2'd0;
        busy      = 1'b0;
        sram_ctrl = '0;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    nrows_d = nrows_in;
                    ncols_d = ncols_in;
                    byp_d   = bypass_conv;
                    state_d = S_RX_GO;
                end
            end
            S_RX_GO: begin
                cnt_d   = 8'd0;
                state_d = S_RX_ACK;
            end
            S_RX_ACK: begin
                if (rx_busy) begin
                    state_d = S_RX_RUN;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == ACK_LIM) state_d = S_ERROR;
                end
            end
            S_RX_RUN: if (!rx_busy) state_d = byp_q ? S_TX_GO : S_CV_GO;
            S_CV_GO: begin
                cnt_d   = 8'd0;
                state_d = S_CV_ACK;
            end
            S_CV_ACK: begin
                if (conv_busy) begin
                    state_d = S_CV_RUN;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == ACK_LIM) state_d = S_ERROR;
                end
            end
            S_CV_RUN: if (!conv_busy) state_d = S_TX_GO;
            S_TX_GO: begin
                cnt_d   = 8'd0;
                state_d = S_TX_ACK;
            end
            S_TX_ACK: begin
                if (tx_busy) begin
                    state_d = S_TX_RUN;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == ACK_LIM) state_d = S_ERROR;
                end
            end
            S_TX_RUN: if (!tx_busy) state_d = S_DONE;
            default:  state_d = S_IDLE;
        endcase

        // SRAM ownership and phase follow the current state only, so they change only on transitions.
        case (state_q)
            S_RX_GO, S_RX_ACK, S_RX_RUN: begin
                phase     = 2'd1;
                busy      = 1'b1;
                sram_ctrl = rx_sram_ctrl;
                rx_en     = (state_q == S_RX_GO);
            end
            S_CV_GO, S_CV_ACK, S_CV_RUN: begin
                phase     = 2'd2;
                busy      = 1'b1;
                sram_ctrl = conv_sram_ctrl;
                conv_en   = (state_q == S_CV_GO);
            end
            S_TX_GO, S_TX_ACK, S_TX_RUN: begin
                phase     = 2'd3;
                busy      = 1'b1;
                sram_ctrl = tx_sram_ctrl;
                tx_en     = (state_q == S_TX_GO);
            end
            default: ;
        endcase

        done_d = (state_d == S_DONE) && (state_q != S_DONE);
    end

    assign nrows = nrows_q;
    assign ncols = ncols_q;
    assign done  = done_q;
    assign err   = (state_q == S_ERROR);

endmodule

// File: tb/tb_img_flow_sequencer.sv
// Randomised and directed runs of img_flow_sequencer against a per-cycle expected trace built from phase timing rules.
module tb_img_flow_sequencer;
    import img_sram_pkg::*;

    localparam int T     = 4;
    localparam int NEVER = 99;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic           bypass_conv = 1'b0;
    logic [7:0]     nrows_in = 8'd0;
    logic [7:0]     ncols_in = 8'd0;
    logic [7:0]     nrows, ncols;
    logic           rx_en, conv_en, tx_en;
    logic           rx_busy, conv_busy, tx_busy;
    img_sram_ctrl_t rx_c, cv_c, tx_c, sram_ctrl;
    logic [1:0]     phase;
    logic           busy, done, err;

    logic rx_mb = 1'b0, cv_mb = 1'b0, tx_mb = 1'b0, tx_stray = 1'b0;
    logic rx_act = 1'b0, cv_act = 1'b0, tx_act = 1'b0;
    int   dly [3];
    int   hold [3];
    int   errors = 0;
    int   checks = 0;
    logic [7:0] lat_r, lat_c;

    assign rx_busy   = rx_mb;
    assign conv_busy = cv_mb;
    assign tx_busy   = tx_mb | tx_stray;

    typedef struct {
        logic [1:0] ph;
        logic [2:0] en;
        logic       dn;
        logic       er;
    } exp_t;
    exp_t q[$];

    img_flow_sequencer #(.ACK_TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .start(start), .bypass_conv(bypass_conv),
        .nrows_in(nrows_in), .ncols_in(ncols_in), .nrows(nrows), .ncols(ncols),
        .rx_en(rx_en), .conv_en(conv_en), .tx_en(tx_en),
        .rx_busy(rx_busy), .conv_busy(conv_busy), .tx_busy(tx_busy),
        .rx_sram_ctrl(rx_c), .conv_sram_ctrl(cv_c), .tx_sram_ctrl(tx_c),
        .sram_ctrl(sram_ctrl), .phase(phase), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Controller models: busy rises dly cycles after the en cycle (0 = within it) and stays up hold cycles.
    always begin : rx_model
        @(negedge clk);
        if (rx_en && dly[0] < 50) begin
            rx_act = 1'b1;
            repeat (dly[0]) @(posedge clk);
            #1 rx_mb = 1'b1;
            repeat (hold[0]) @(posedge clk);
            #1 rx_mb = 1'b0;
            rx_act = 1'b0;
        end
    end

    always begin : cv_model
        @(negedge clk);
        if (conv_en && dly[1] < 50) begin
            cv_act = 1'b1;
            repeat (dly[1]) @(posedge clk);
            #1 cv_mb = 1'b1;
            repeat (hold[1]) @(posedge clk);
            #1 cv_mb = 1'b0;
            cv_act = 1'b0;
        end
    end

    always begin : tx_model
        @(negedge clk);
        if (tx_en && dly[2] < 50) begin
            tx_act = 1'b1;
            repeat (dly[2]) @(posedge clk);
            #1 tx_mb = 1'b1;
            repeat (hold[2]) @(posedge clk);
            #1 tx_mb = 1'b0;
            tx_act = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [79:0] obs_now();
        return {12'd0, phase, tx_en, conv_en, rx_en, busy, done, err, nrows, ncols, sram_ctrl};
    endfunction

    function automatic logic [79:0] exp_pack(input exp_t e);
        img_sram_ctrl_t s;
        case (e.ph)
            2'd1:    s = rx_c;
            2'd2:    s = cv_c;
            2'd3:    s = tx_c;
            default: s = '0;
        endcase
        return {12'd0, e.ph, e.en, (e.ph != 2'd0), e.dn, e.er, lat_r, lat_c, s};
    endfunction

    task automatic push(input int ph, input int en, input bit dn, input bit er);
        exp_t e;
        e.ph = 2'(ph);
        e.en = 3'(en);
        e.dn = dn;
        e.er = er;
        q.push_back(e);
    endtask

    // Expected trace from the first cycle after start is accepted: GO, ack wait, run, then DONE or ERROR.
    task automatic build(input bit byp, output int tx_idx);
        int acks, runs;
        q.delete();
        tx_idx = -1;
        for (int p = 0; p < 3; p++) begin
            if (p == 1 && byp) continue;
            push(p + 1, 1 << p, 1'b0, 1'b0);
            if (dly[p] > T) begin
                repeat (T) push(p + 1, 0, 1'b0, 1'b0);
                push(0, 0, 1'b0, 1'b1);
                push(0, 0, 1'b0, 1'b1);
                return;
            end
            acks = (dly[p] == 0) ? 1 : dly[p];
            runs = dly[p] + hold[p] - acks;
            repeat (acks) push(p + 1, 0, 1'b0, 1'b0);
            if (p == 2) tx_idx = q.size() + runs / 2;
            repeat (runs) push(p + 1, 0, 1'b0, 1'b0);
        end
        push(0, 0, 1'b1, 1'b0);
        push(0, 0, 1'b0, 1'b0);
    endtask

    task automatic wait_quiet(input string tag);
        int n = 0;
        @(negedge clk);
        while ((rx_act | cv_act | tx_act | rx_busy | conv_busy | tx_busy) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_quiet"}, 80'(n < 400), 80'd1);
    endtask

    // mode 0: plain run; 1: ignored start and stray tx_busy during RX_RUN; 2: async reset mid TX_RUN.
    task automatic run(input string tag, input bit byp, input logic [7:0] r, input logic [7:0] c,
                       input int mode);
        int tx_idx;
        int ign;
        wait_quiet(tag);
        build(byp, tx_idx);
        lat_r = r;
        lat_c = c;
        nrows_in = r;
        ncols_in = c;
        bypass_conv = byp;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        nrows_in = 8'($urandom);
        ncols_in = 8'($urandom);
        bypass_conv = ~byp;
        ign = ((dly[0] == 0) ? 1 : dly[0]) + 2;
        for (int i = 0; i < q.size(); i++) begin
            @(negedge clk);
            chk($sformatf("%s[%0d]", tag, i), obs_now(), exp_pack(q[i]));
            if (mode == 1) begin
                start = (i == ign);
                if (i == ign) nrows_in = 8'd5;
                tx_stray = (i >= ign + 3 && i < ign + 6);
            end
            if (mode == 2 && i == tx_idx) begin
                #2 rst = 1'b1;
                #1 chk({tag, "_rst_async"}, obs_now(), 80'd0);
                repeat (3) begin
                    @(negedge clk);
                    chk({tag, "_rst_hold"}, obs_now(), 80'd0);
                end
                rst = 1'b0;
                break;
            end
        end
    endtask

    task automatic set_ctl(input int d0, input int d1, input int d2,
                           input int h0, input int h1, input int h2);
        dly[0] = d0; dly[1] = d1; dly[2] = d2;
        hold[0] = h0; hold[1] = h1; hold[2] = h2;
    endtask

    initial begin
        logic [63:0] rnd;
        rnd = {$urandom, $urandom}; rx_c = rnd[43:0]; rx_c.cs = 1'b1;
        rnd = {$urandom, $urandom}; cv_c = rnd[43:0]; cv_c.cs = 1'b1;
        rnd = {$urandom, $urandom}; tx_c = rnd[43:0]; tx_c.cs = 1'b1;
        set_ctl(1, 1, 1, 4, 4, 4);
        start = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("reset_state", obs_now(), 80'd0);
        end
        start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", obs_now(), 80'd0);

        set_ctl(1, 1, 1, 16384, 16384, 16384);
        run("nominal", 1'b0, 8'd128, 8'd128, 1);

        set_ctl($urandom_range(1, T), $urandom_range(1, T), $urandom_range(1, T),
                $urandom_range(5, 20), $urandom_range(5, 20), $urandom_range(5, 20));
        run("bypass", 1'b1, 8'($urandom), 8'($urandom), 0);

        set_ctl(T, T, T, 1, 1, 1);
        run("ack_at_limit", 1'b0, 8'd1, 8'd255, 0);

        set_ctl(0, 0, 0, 2, 3, 2);
        run("busy_in_go", 1'b0, 8'd7, 8'd9, 0);

        set_ctl(1, NEVER, 1, 3, 3, 3);
        run("conv_timeout", 1'b0, 8'd64, 8'd32, 0);

        set_ctl(2, 1, 3, 5, 4, 6);
        run("restart_after_err", 1'b0, 8'd17, 8'd18, 0);

        set_ctl(T + 1, 1, 1, 3, 3, 3);
        run("rx_late_ack", 1'b0, 8'd200, 8'd100, 0);

        set_ctl(2, 2, 2, 10, 10, 10);
        run("async_reset", 1'b0, 8'd128, 8'd128, 2);

        for (int k = 0; k < 8; k++) begin
            set_ctl($urandom_range(0, T + 1), $urandom_range(0, T + 1), $urandom_range(0, T + 1),
                    $urandom_range(2, 12), $urandom_range(2, 12), $urandom_range(2, 12));
            run($sformatf("rand%0d", k), 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 0);
        end

        wait_quiet("final");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
